// File: rtl/pool_pkg.sv
// pool_pkg: shared types, widths and window-count helper for the 3x3 pooling scheduler
package pool_pkg;
  localparam int DATA_W_DEF = 16;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int win_count(input int w, input int h, input int s);
    return ((w - 3) / s + 1) * ((h - 3) / s + 1);
  endfunction
endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: single-port line buffer, combinational read, synchronous write at the same address
module pool_line_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  assign rdata = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/pool_window_ctrl.sv
// pool_window_ctrl: buffers two lines of a raster frame and emits strided 3x3 windows to the pooling unit
module pool_window_ctrl import pool_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int STRIDE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [DATA_W-1:0] pix_data,
  output logic              win_valid,
  output logic [DATA_W-1:0] win0,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic [DATA_W-1:0] win4,
  output logic [DATA_W-1:0] win5,
  output logic [DATA_W-1:0] win6,
  output logic [DATA_W-1:0] win7,
  output logic [DATA_W-1:0] win8,
  output logic              frame_done
);
  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [1:0] P_LAST = 2'(STRIDE - 1);
  state_t state;
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic [1:0] cph, rph;
  logic [DATA_W-1:0] t0, t1, m0, m1, m2, n0, n1, n2;
  logic acc, c_wrap, last, win_hit;
  assign busy = (state == RUN);
  assign pix_ready = (state == RUN);
  assign acc = pix_valid & pix_ready;
  assign c_wrap = (c == C_LAST);
  assign last = c_wrap && (r == R_LAST);
  assign win_hit = (r >= RW'(2)) && (c >= CW'(2)) && (rph == 2'd0) && (cph == 2'd0);
  pool_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) lb0 (
    .clk(clk), .we(acc), .addr(c), .wdata(t1), .rdata(t0)
  );
  pool_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) lb1 (
    .clk(clk), .we(acc), .addr(c), .wdata(pix_data), .rdata(t1)
  );
  // m* holds the older and n* the newer of the two previous columns, top row first
  always_ff @(posedge clk)
    if (acc) begin
      {m0, m1, m2} <= {n0, n1, n2};
      {n0, n1, n2} <= {t0, t1, pix_data};
    end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      c <= '0;
      r <= '0;
      cph <= '0;
      rph <= '0;
      win_valid <= 1'b0;
      frame_done <= 1'b0;
      {win0, win1, win2, win3, win4, win5, win6, win7, win8} <= '0;
    end else begin
      win_valid <= 1'b0;
      frame_done <= 1'b0;
      if (state == IDLE && start && !frame_done) begin
        state <= RUN;
        c <= '0;
        r <= '0;
        cph <= '0;
        rph <= '0;
      end
      if (acc) begin
        c <= c_wrap ? '0 : c + CW'(1);
        cph <= (c_wrap || c < CW'(2) || cph == P_LAST) ? 2'd0 : cph + 2'd1;
        if (c_wrap) begin
          r <= r + RW'(1);
          rph <= (r < RW'(2) || rph == P_LAST) ? 2'd0 : rph + 2'd1;
        end
        if (win_hit) begin
          win_valid <= 1'b1;
          {win0, win1, win2} <= {m0, n0, t0};
          {win3, win4, win5} <= {m1, n1, t1};
          {win6, win7, win8} <= {m2, n2, pix_data};
        end
        if (last) begin
          state <= IDLE;
          frame_done <= 1'b1;
        end
      end
    end
  end
endmodule
